encoder_74ls148: RTL and testbench

Clocked 8-to-3 priority encoder with active-low inputs and outputs, equivalent to a 74LS148 with one register stage.
- Input 7 has the highest priority.
- Enable-output (EO) and group-select (GS) support cascading several encoders into wider priority encoders.
- Used wherever a registered, TTL-compatible priority encode of eight request lines is required.

---
 rtl/enc74_pkg.sv | 17 +
 rtl/prio_enc8_core.sv | 25 ++
 rtl/encoder_74ls148.sv | 35 +++
 tb/tb_encoder_74ls148.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/enc74_pkg.sv
// Shared types and constants for the registered 74LS148-style priority encoder.
package enc74_pkg;

    localparam logic [2:0] Q_NONE   = 3'b111;
    localparam logic       GS_OFF   = 1'b1;
    localparam logic       EO_OFF   = 1'b1;
    localparam logic       EO_EMPTY = 1'b0;

    typedef struct packed {
        logic [2:0] q;
        logic       gs;
        logic       eo;
    } enc74_out_t;

    localparam enc74_out_t OUT_DISABLED = '{q: Q_NONE, gs: GS_OFF, eo: EO_OFF};

endpackage

// File: rtl/prio_enc8_core.sv
// Combinational 8-to-3 priority decode, active-low in and out; I[7] wins.
module prio_enc8_core
    import enc74_pkg::*;
(
    input  logic [7:0]  I,
    input  logic        EN,
    output enc74_out_t  out
);

    always_comb begin
        out = OUT_DISABLED;
        if (!EN) begin
            out.eo = EO_EMPTY;
            // Ascending scan so the highest active index is the last one written.
            for (int k = 0; k < 8; k++) begin
                if (!I[k]) begin
                    out.q  = ~3'(k);
                    out.gs = 1'b0;
                    out.eo = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/encoder_74ls148.sv
// 74LS148 priority encoder with a single output register stage (one-cycle latency).
module encoder_74ls148
    import enc74_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  I,
    input  logic        EN,
    output logic [2:0]  Q,
    output logic        GS,
    output logic        EO
);

    enc74_out_t out_d;
    enc74_out_t out_q;

    prio_enc8_core u_core (
        .I   (I),
        .EN  (EN),
        .out (out_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= OUT_DISABLED;
        end else begin
            out_q <= out_d;
        end
    end

    assign Q  = out_q.q;
    assign GS = out_q.gs;
    assign EO = out_q.eo;

endmodule

// File: tb/tb_encoder_74ls148.sv
// Scoreboard bench for encoder_74ls148: driver queues expected {Q,GS,EO}, monitor checks per edge.
module tb_encoder_74ls148;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] I = 8'h00;
    logic       EN = 1'b0;
    logic [2:0] Q;
    logic       GS;
    logic       EO;

    logic [7:0] i_lo = 8'hF7;
    logic [2:0] q_lo;
    logic       gs_lo;
    logic       eo_lo;

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    encoder_74ls148 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .EN    (EN),
        .Q     (Q),
        .GS    (GS),
        .EO    (EO)
    );

    // Lower-priority stage of a cascade, enabled by the upper stage's EO.
    encoder_74ls148 u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (i_lo),
        .EN    (EO),
        .Q     (q_lo),
        .GS    (gs_lo),
        .EO    (eo_lo)
    );

    function automatic logic [4:0] ref_model(logic [7:0] i, logic en);
        if (en) return 5'b111_1_1;
        if (i == 8'hFF) return 5'b111_1_0;
        for (int n = 7; n >= 0; n--) begin
            if (!i[n]) return {~3'(n), 1'b0, 1'b1};
        end
        return 5'bxxxxx;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got Q/GS/EO=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Change inputs away from the edge and queue what the next rising edge must produce.
    task automatic drive(input logic [7:0] i, input logic en, input logic [4:0] exp);
        @(negedge clk);
        I  = i;
        EN = en;
        sb.push_back(exp);
    endtask

    initial begin : monitor
        logic [4:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("scoreboard", {Q, GS, EO}, exp);
                n_vec++;
                if (!GS && !EO) begin
                    n_err++;
                    $display("FAIL gs_eo_excl: got GS=%b EO=%b required not both 0", GS, EO);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held with an active request: outputs must show the disabled code.
        #12;
        check("reset_hold", {Q, GS, EO}, 5'b111_1_1);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(5'b000_0_1);

        drive(8'h00, 1'b1, 5'b111_1_1);
        drive(8'hFF, 1'b0, 5'b111_1_0);
        drive(8'h7F, 1'b0, 5'b000_0_1);
        drive(8'hFE, 1'b0, 5'b111_0_1);
        drive(8'hEF, 1'b0, 5'b011_0_1);
        drive(8'h00, 1'b0, 5'b000_0_1);
        drive(8'hFB, 1'b0, 5'b101_0_1);
        drive(8'hFF, 1'b0, 5'b111_1_0);
        drive(8'hBF, 1'b0, 5'b001_0_1);
        drive(8'hBF, 1'b1, 5'b111_1_1);

        for (int v = 0; v < 256; v++) begin
            drive(8'(v), 1'b0, ref_model(8'(v), 1'b0));
        end

        // Cascade: lower stage sees EN low one edge after the upper stage runs empty.
        drive(8'hFF, 1'b0, 5'b111_1_0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("cascade_lo_enabled", {q_lo, gs_lo, eo_lo}, 5'b100_0_1);
        drive(8'h7F, 1'b0, 5'b000_0_1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("cascade_lo_disabled", {q_lo, gs_lo, eo_lo}, 5'b111_1_1);

        // Mid-operation reset between edges with Q=000 registered.
        @(posedge clk);
        #2;
        check("pre_midreset", {Q, GS, EO}, 5'b000_0_1);
        rst_n = 1'b0;
        #1;
        check("midreset_async", {Q, GS, EO}, 5'b111_1_1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midreset_released_no_edge", {Q, GS, EO}, 5'b111_1_1);
        sb.push_back(5'b000_0_1);

        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(posedge clk);
            #2;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
